gpio_en_sequencer: RTL and testbench

//  Avalon-MM slave that sequences the display 'en' line instead of passing a raw register bit.

---
 rtl/gpio_en_sequencer.sv | 172 +++++++++++++++++
 tb/tb_gpio_en_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_en_sequencer.sv
// gpio_en_sequencer: Avalon-MM slave that sequences the display enable line.
// Software programs a start delay and pulse length, then sets req; 'en' rises
// after the delay and either stays high (continuous) or self-clears (one-shot).
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | en low, waiting for a CTRL write with req=1
// S_WAIT | start delay running, cnt counts DELAY down to 0
// S_ON   | en high; one-shot counts the latched PULSE down, continuous holds
module gpio_en_sequencer #(
  parameter int CNT_W     = 24,
  parameter int DEF_DELAY = 0,
  parameter int DEF_PULSE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_n,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        en
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ON   = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_pulse;
  logic [CNT_W-1:0] r_pulse_l;
  logic             r_req;
  logic             r_mode;
  logic             r_mode_l;
  logic             r_done;
  logic             r_en;
  logic             w_en_nxt;
  logic             w_finish;
  logic             w_start;
  logic             w_abort;
  logic             w_wr_ctrl;
  logic             w_wr_delay;
  logic             w_wr_pulse;
  logic             w_wr_status;
  logic             w_unused;

  assign w_wr_ctrl   = !write_n && (address == 2'd0);
  assign w_wr_delay  = !write_n && (address == 2'd1);
  assign w_wr_pulse  = !write_n && (address == 2'd2);
  assign w_wr_status = !write_n && (address == 2'd3);

  assign w_start = w_wr_ctrl && writedata[0] && (r_state == S_IDLE);
  assign w_abort = w_wr_ctrl && !writedata[0] && (r_state != S_IDLE);

  // Upper write-data bits beyond the counter width carry no meaning.
  assign w_unused = ^writedata[31:CNT_W];

  // Next-state, counter and enable decisions for the sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = r_en;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = r_delay;
        end
      end
      S_WAIT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_en_nxt    = 1'b0;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_ON;
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = r_pulse_l;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_ON: begin
        // One-shot completion outranks a same-edge CTRL write.
        if (r_mode_l && (r_cnt == '0)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
          w_en_nxt    = 1'b0;
        end else if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_en_nxt    = 1'b0;
        end else if (r_mode_l) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  // Sequencer state, counter and registered enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
    end
  end

  // Software-visible registers plus the values captured at start.
  // PULSE is captured at start so a rewrite during the delay only affects the next run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req     <= 1'b0;
      r_mode    <= 1'b0;
      r_mode_l  <= 1'b0;
      r_pulse_l <= '0;
      r_done    <= 1'b0;
      r_delay   <= CNT_W'(DEF_DELAY);
      r_pulse   <= CNT_W'(DEF_PULSE);
    end else begin
      if (w_finish) begin
        r_req <= 1'b0;
      end else if (w_wr_ctrl) begin
        r_req <= writedata[0];
      end
      if (w_wr_ctrl) begin
        r_mode <= writedata[1];
      end
      if (w_start) begin
        r_mode_l  <= writedata[1];
        r_pulse_l <= r_pulse;
      end
      if (w_finish) begin
        r_done <= 1'b1;
      end else if (w_wr_status && writedata[3]) begin
        r_done <= 1'b0;
      end
      if (w_wr_delay) begin
        r_delay <= writedata[CNT_W-1:0];
      end
      if (w_wr_pulse) begin
        r_pulse <= writedata[CNT_W-1:0];
      end
    end
  end

  // Read-back mux, zero-extended.
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {30'd0, r_mode, r_req};
      2'd1:    readdata = 32'(r_delay);
      2'd2:    readdata = 32'(r_pulse);
      default: readdata = {28'd0, r_done, r_state, r_en};
    endcase
  end

  assign en = r_en;

endmodule

// File: tb/tb_gpio_en_sequencer.sv
// tb_gpio_en_sequencer: scoreboard bench with a timestamp-based reference model.
module tb_gpio_en_sequencer;

  localparam int CNT_W     = 24;
  localparam int DEF_DELAY = 4;
  localparam int DEF_PULSE = 1;
  localparam int unsigned CNT_MASK = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_n;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        en;

  gpio_en_sequencer #(
    .CNT_W     (CNT_W),
    .DEF_DELAY (DEF_DELAY),
    .DEF_PULSE (DEF_PULSE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .write_n   (write_n),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .en        (en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en_e;
    logic [31:0] rd_e;
    logic [1:0]  addr;
    longint      edge_no;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a run is described by the edge numbers at which en
  // rises and (one-shot only) the edge at which the run finishes.
  longint      k;
  bit          m_busy, m_mode_l, m_req, m_mode, m_done;
  longint      t_rise, t_end;
  int unsigned m_delay, m_pulse;

  function automatic void model_reset();
    k        = 0;
    m_busy   = 0;
    m_mode_l = 0;
    m_req    = 0;
    m_mode   = 0;
    m_done   = 0;
    t_rise   = 0;
    t_end    = 0;
    m_delay  = DEF_DELAY;
    m_pulse  = DEF_PULSE;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a, input bit m_en);
    logic [1:0] st;
    st = !m_busy ? 2'b00 : ((k >= t_rise) ? 2'b10 : 2'b01);
    case (a)
      2'd0:    return {30'd0, m_mode, m_req};
      2'd1:    return m_delay;
      2'd2:    return m_pulse;
      default: return {28'd0, m_done, st, m_en};
    endcase
  endfunction

  // One bus cycle: drive at negedge, advance the model across the next edge.
  task automatic step(input logic wn, input logic [1:0] a, input logic [31:0] wd);
    bit   comp, wr_ctrl;
    exp_t e;
    @(negedge clk);
    write_n   = wn;
    address   = a;
    writedata = wd;
    k       = k + 1;
    wr_ctrl = !wn && (a == 2'd0);
    comp    = m_busy && m_mode_l && (k == t_end);
    if (comp) begin
      m_busy = 0;
    end else if (m_busy && wr_ctrl && !wd[0]) begin
      m_busy = 0;
    end else if (!m_busy && wr_ctrl && wd[0]) begin
      m_busy   = 1;
      m_mode_l = wd[1];
      t_rise   = k + m_delay + 1;
      t_end    = t_rise + m_pulse + 1;
    end
    if (comp)         m_req = 0;
    else if (wr_ctrl) m_req = wd[0];
    if (wr_ctrl)      m_mode = wd[1];
    if (comp)                            m_done = 1;
    else if (!wn && a == 2'd3 && wd[3])  m_done = 0;
    if (!wn && a == 2'd1) m_delay = wd & CNT_MASK;
    if (!wn && a == 2'd2) m_pulse = wd & CNT_MASK;
    e.en_e    = m_busy && (k >= t_rise);
    e.rd_e    = model_read(a, e.en_e);
    e.addr    = a;
    e.edge_no = k;
    q.push_back(e);
  endtask

  // Monitor: compares DUT outputs just after each edge against the queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (en !== e.en_e || readdata !== e.rd_e) begin
        bad++;
        $display("FAIL edge%0d addr=%0d: got en=%b rd=0x%08h, want en=%b rd=0x%08h",
                 e.edge_no, e.addr, en, readdata, e.en_e, e.rd_e);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 32'd0);
  endtask

  initial begin
    logic [31:0] wd;
    logic [1:0]  a;
    reset     = 1'b0;
    write_n   = 1'b1;
    address   = 2'd0;
    writedata = 32'd0;
    model_reset();
    #1;
    total++;
    if (en !== 1'b0) begin
      bad++;
      $display("FAIL reset_en: got %b, want 0", en);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset values on all four addresses.
    read_all();

    // Continuous, DELAY=5, then abort from ON.
    step(1'b0, 2'd1, 32'd5);
    step(1'b0, 2'd0, 32'd1);
    repeat (8) step(1'b1, 2'd3, 32'd0);
    step(1'b0, 2'd0, 32'd0);
    step(1'b1, 2'd3, 32'd0);

    // One-shot DELAY=2 PULSE=3, then W1C of done.
    step(1'b0, 2'd1, 32'd2);
    step(1'b0, 2'd2, 32'd3);
    step(1'b0, 2'd0, 32'd3);
    repeat (8) step(1'b1, 2'd3, 32'd0);
    step(1'b1, 2'd0, 32'd0);
    step(1'b0, 2'd3, 32'd8);
    step(1'b1, 2'd3, 32'd0);

    // Abort during a long delay.
    step(1'b0, 2'd1, 32'd100);
    step(1'b0, 2'd0, 32'd1);
    repeat (49) step(1'b1, 2'd3, 32'd0);
    step(1'b0, 2'd0, 32'd0);
    repeat (3) step(1'b1, 2'd3, 32'd0);

    // Rewrites while a one-shot is running; next start uses the new PULSE.
    step(1'b0, 2'd1, 32'd2);
    step(1'b0, 2'd2, 32'd3);
    step(1'b0, 2'd0, 32'd3);
    repeat (3) step(1'b1, 2'd3, 32'd0);
    step(1'b0, 2'd2, 32'd10);
    step(1'b0, 2'd0, 32'd3);
    repeat (6) step(1'b1, 2'd3, 32'd0);
    step(1'b0, 2'd3, 32'd8);
    step(1'b0, 2'd0, 32'd3);
    repeat (16) step(1'b1, 2'd3, 32'd0);

    // Reset asserted between edges while en is high.
    step(1'b0, 2'd1, 32'd1);
    step(1'b0, 2'd0, 32'd1);
    repeat (4) step(1'b1, 2'd3, 32'd0);
    drain();
    total++;
    if (en !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_en: got %b, want 1", en);
    end
    reset = 1'b0;
    #1;
    total++;
    if (en !== 1'b0 || readdata !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: got en=%b status=0x%08h, want en=0 status=0x00000000", en, readdata);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    read_all();

    // Randomized traffic with small counts so runs complete and overlap writes.
    repeat (800) begin
      a = 2'($urandom_range(3, 0));
      if ($urandom_range(99, 0) < 60) begin
        step(1'b1, a, $urandom());
      end else begin
        wd = ($urandom() & 32'hFF00_0000) | 32'($urandom_range(7, 0));
        if (a == 2'd0 || a == 2'd3) wd = $urandom();
        step(1'b0, a, wd);
      end
    end
    step(1'b1, 2'd3, 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
